// File: rtl/uart_tx_fifo_param.sv
// uart_tx_fifo_param
//   Parametrised UART transmitter with an input byte FIFO. Producers push
//   characters into the FIFO; the serializer drains it and emits
//   start / data (LSB first) / optional parity / stop bits on uart_tx_out.
//   Frames are sent back-to-back with no idle gap while data is queued.
//
// Ports
//   clk          system clock, rising edge
//   rst_pin      asynchronous active-high reset
//   wr_en        push wr_data into the FIFO this cycle
//   wr_data      character to transmit (DATA_BITS wide)
//   full         FIFO holds FIFO_DEPTH entries (registered)
//   empty        FIFO holds no entries (registered)
//   count        current FIFO occupancy
//   overflow     one-cycle pulse after a write attempted while full
//   busy         serializer is not idle
//   uart_tx_out  serial line, idle high, registered
module uart_tx_fifo_param #(
    parameter int unsigned CLKS_PER_BIT = 10416,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY       = 0,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned FIFO_DEPTH   = 16,
    parameter int unsigned FIFO_AW      = 4
) (
    input  logic                 clk,
    input  logic                 rst_pin,
    input  logic                 wr_en,
    input  logic [DATA_BITS-1:0] wr_data,
    output logic                 full,
    output logic                 empty,
    output logic [FIFO_AW:0]     count,
    output logic                 overflow,
    output logic                 busy,
    output logic                 uart_tx_out
);

    localparam int unsigned     CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0]   CNT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]      DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]      STOP_LAST = 4'(STOP_BITS - 1);
    localparam logic [FIFO_AW:0] DEPTH_V  = (FIFO_AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    // ---------------------------------------------------------------- FIFO
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [FIFO_AW-1:0]   wr_ptr;
    logic [FIFO_AW-1:0]   rd_ptr;
    logic [FIFO_AW:0]     count_next;
    logic                 push;
    logic                 pop;
    logic [DATA_BITS-1:0] head;
    logic                 head_par;

    // Acceptance uses the registered full flag, so a simultaneous pop never
    // rescues a write issued while full.
    assign push = wr_en && !full;
    assign head = mem[rd_ptr];
    assign head_par = (PARITY == 1) ? ~^head : ^head;

    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + 1'b1;
        end else if (!push && pop) begin
            count_next = count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst_pin) begin
        if (rst_pin) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count    <= count_next;
            full     <= (count_next == DEPTH_V);
            empty    <= (count_next == '0);
            overflow <= wr_en && full;
        end
    end

    // ---------------------------------------------------------- serializer
    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [3:0]           bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 tx_q, tx_d;
    logic                 bit_end;

    assign bit_end     = (cnt_q == CNT_LAST);
    assign busy        = (state_q != ST_IDLE);
    assign uart_tx_out = tx_q;

    always_ff @(posedge clk or posedge rst_pin) begin
        if (rst_pin) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
        end
    end

    // tx_d is the level for the bit that begins on this edge, so the line
    // itself is a flop and changes exactly at bit boundaries.
    always_comb begin
        state_d = state_q;
        cnt_d   = bit_end ? '0 : cnt_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        tx_d    = tx_q;
        pop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                tx_d  = 1'b1;
                cnt_d = '0;
                bit_d = '0;
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = head;
                    par_d   = head_par;
                    tx_d    = 1'b0;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    state_d = ST_DATA;
                    bit_d   = '0;
                    tx_d    = shift_q[0];
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    if (bit_q == DATA_LAST) begin
                        bit_d = '0;
                        if (PARITY != 0) begin
                            state_d = ST_PARITY;
                            tx_d    = par_q;
                        end else begin
                            state_d = ST_STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                    end
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    state_d = ST_STOP;
                    bit_d   = '0;
                    tx_d    = 1'b1;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    if (bit_q == STOP_LAST) begin
                        bit_d = '0;
                        // Chain straight into the next start bit when data waits.
                        if (!empty) begin
                            pop     = 1'b1;
                            shift_d = head;
                            par_d   = head_par;
                            tx_d    = 1'b0;
                            state_d = ST_START;
                        end else begin
                            tx_d    = 1'b1;
                            state_d = ST_IDLE;
                        end
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_fifo_param.sv
// Testbench for uart_tx_fifo_param. Four instances share clk/rst_pin:
//   u0: defaults (8N1, depth 16), u1: even parity + 2 stop bits,
//   u2: odd parity, u3: depth 4. All use 16 clocks per bit.
// Written bytes are pushed to a scoreboard queue and popped when a frame
// is decoded from the serial line.
module tb_uart_tx_fifo_param;

    localparam int CPB  = 16;
    localparam int HALF = 8;

    logic       clk = 1'b0;
    logic       rst_pin = 1'b1;
    logic       wr_en   [4];
    logic [7:0] wr_data [4];
    logic       full    [4];
    logic       empty   [4];
    logic       overflow[4];
    logic       busy    [4];
    logic       tx      [4];
    logic [4:0] cnt16   [3];
    logic [2:0] cnt4;

    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    logic [7:0] sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_fifo_param #(.CLKS_PER_BIT(16)) u0 (
        .clk(clk), .rst_pin(rst_pin), .wr_en(wr_en[0]), .wr_data(wr_data[0]),
        .full(full[0]), .empty(empty[0]), .count(cnt16[0]), .overflow(overflow[0]),
        .busy(busy[0]), .uart_tx_out(tx[0]));

    uart_tx_fifo_param #(.CLKS_PER_BIT(16), .PARITY(2), .STOP_BITS(2)) u1 (
        .clk(clk), .rst_pin(rst_pin), .wr_en(wr_en[1]), .wr_data(wr_data[1]),
        .full(full[1]), .empty(empty[1]), .count(cnt16[1]), .overflow(overflow[1]),
        .busy(busy[1]), .uart_tx_out(tx[1]));

    uart_tx_fifo_param #(.CLKS_PER_BIT(16), .PARITY(1)) u2 (
        .clk(clk), .rst_pin(rst_pin), .wr_en(wr_en[2]), .wr_data(wr_data[2]),
        .full(full[2]), .empty(empty[2]), .count(cnt16[2]), .overflow(overflow[2]),
        .busy(busy[2]), .uart_tx_out(tx[2]));

    uart_tx_fifo_param #(.CLKS_PER_BIT(16), .FIFO_DEPTH(4), .FIFO_AW(2)) u3 (
        .clk(clk), .rst_pin(rst_pin), .wr_en(wr_en[3]), .wr_data(wr_data[3]),
        .full(full[3]), .empty(empty[3]), .count(cnt4), .overflow(overflow[3]),
        .busy(busy[3]), .uart_tx_out(tx[3]));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] cnt_of(input int id);
        if (id == 3) return {29'b0, cnt4};
        else if (id >= 0 && id < 3) return {27'b0, cnt16[id]};
        else return '1;
    endfunction

    function automatic bit idle_ok(input int id);
        return tx[id] === 1'b1 && empty[id] === 1'b1 && full[id] === 1'b0 &&
               cnt_of(id) == 0 && busy[id] === 1'b0 && overflow[id] === 1'b0;
    endfunction

    // One write cycle; the edge consuming it is the next posedge.
    task automatic wr(input int id, input logic [7:0] d);
        wr_en[id]   = 1'b1;
        wr_data[id] = d;
        sb.push_back(d);
        @(negedge clk);
        wr_en[id] = 1'b0;
    endtask

    task automatic rx_frame(input int id, input int npar, input int nstop,
                            output logic [7:0] d, output logic p, output int t0);
        int w = 0;
        d  = '0;
        p  = 1'b0;
        t0 = 0;
        while (tx[id] !== 1'b0 && w < 3000) begin
            @(negedge clk);
            w++;
        end
        if (tx[id] !== 1'b0) begin
            check("rx_start_timeout", 1, 0);
            return;
        end
        t0 = cyc;
        repeat (HALF) @(negedge clk);
        check("rx_start_bit", tx[id], 0);
        for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(negedge clk);
            d[i] = tx[id];
        end
        if (npar != 0) begin
            repeat (CPB) @(negedge clk);
            p = tx[id];
        end
        for (int s = 0; s < nstop; s++) begin
            repeat (CPB) @(negedge clk);
            check("rx_stop_bit", tx[id], 1);
        end
    endtask

    // pkind: 0 none, 1 odd, 2 even
    task automatic expect_frame(input int id, input int pkind, input int nstop, output int t0);
        logic [7:0] d;
        logic [7:0] e;
        logic       p;
        rx_frame(id, (pkind != 0) ? 1 : 0, nstop, d, p, t0);
        if (sb.size() == 0) begin
            check("sb_underflow", 1, 0);
            return;
        end
        e = sb.pop_front();
        check("rx_data", d, e);
        if (pkind == 1) check("rx_parity_odd", p, ~^e);
        else if (pkind == 2) check("rx_parity_even", p, ^e);
    endtask

    task automatic measure_busy(input int id, output int n);
        int w = 0;
        n = 0;
        while (busy[id] !== 1'b1 && w < 100) begin
            @(negedge clk);
            w++;
        end
        while (busy[id] === 1'b1 && n < 5000) begin
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         errs;
        int         nb;
        int         t0a;
        int         t0b;
        logic [7:0] e;
        logic       eb;
        int         exp_cnt [6];
        logic       exp_full[6];
        logic       exp_ovf [6];

        for (int i = 0; i < 4; i++) begin
            wr_en[i]   = 1'b0;
            wr_data[i] = '0;
        end

        // 1. reset held 100 cycles, then idle with no writes
        errs = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            for (int id = 0; id < 4; id++) if (!idle_ok(id)) errs++;
        end
        check("t1_reset_hold", errs, 0);
        rst_pin = 1'b0;
        errs = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            for (int id = 0; id < 4; id++) if (!idle_ok(id)) errs++;
        end
        check("t1_idle_after", errs, 0);
        check("t1_tx", tx[0], 1);
        check("t1_empty", empty[0], 1);
        check("t1_full", full[0], 0);
        check("t1_count", cnt_of(0), 0);
        check("t1_busy", busy[0], 0);
        check("t1_overflow", overflow[0], 0);

        // 2. single frame 'S', cycle-exact waveform
        wr(0, 8'h53);
        check("t2_count_after_write", cnt_of(0), 1);
        check("t2_tx_before_pop", tx[0], 1);
        @(negedge clk);
        check("t2_tx_fall", tx[0], 0);
        e = sb.pop_front();
        errs = 0;
        nb = 0;
        for (int i = 0; i < 160; i++) begin
            if (i < 16) eb = 1'b0;
            else if (i < 144) eb = e[i/16 - 1];
            else eb = 1'b1;
            if (tx[0] !== eb) errs++;
            if (busy[0] === 1'b1) nb++;
            @(negedge clk);
        end
        check("t2_waveform", errs, 0);
        check("t2_busy_cycles", nb, 160);
        check("t2_busy_end", busy[0], 0);
        check("t2_tx_end", tx[0], 1);

        // 3. back-to-back 'S','A'
        repeat (5) @(negedge clk);
        wr(0, 8'h53);
        wr(0, 8'h41);
        fork
            begin
                expect_frame(0, 0, 1, t0a);
                expect_frame(0, 0, 1, t0b);
            end
            measure_busy(0, nb);
        join
        check("t3_frame_gap", t0b - t0a, 160);
        check("t3_busy_cycles", nb, 320);

        // 4. parity / stop-bit variants with 0x41
        wr(1, 8'h41);
        fork
            expect_frame(1, 2, 2, t0a);
            measure_busy(1, nb);
        join
        check("t4_even2_busy", nb, 192);
        wr(2, 8'h41);
        fork
            expect_frame(2, 1, 1, t0a);
            measure_busy(2, nb);
        join
        check("t4_odd_busy", nb, 176);

        // 5. overflow on the depth-4 instance
        exp_cnt  = '{1, 1, 2, 3, 4, 4};
        exp_full = '{0, 0, 0, 0, 1, 1};
        exp_ovf  = '{0, 0, 0, 0, 0, 1};
        repeat (3) @(negedge clk);
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    wr_en[3]   = 1'b1;
                    wr_data[3] = 8'h10 + 8'(i);
                    if (i < 5) sb.push_back(8'h10 + 8'(i));
                    @(negedge clk);
                    check("t5_count", cnt_of(3), exp_cnt[i]);
                    check("t5_full", full[3], exp_full[i]);
                    check("t5_overflow", overflow[3], exp_ovf[i]);
                end
                wr_en[3] = 1'b0;
                @(negedge clk);
                check("t5_overflow_drop", overflow[3], 0);
                check("t5_count_hold", cnt_of(3), 4);
            end
            begin
                for (int f = 0; f < 5; f++) expect_frame(3, 0, 1, t0a);
            end
        join
        check("t5_sb_drained", sb.size(), 0);
        repeat (20) @(negedge clk);

        // 6. reset in data bit 3 with two bytes queued
        wr(0, 8'h11);
        wr(0, 8'h22);
        wr(0, 8'h33);
        check("t6_queued", cnt_of(0), 2);
        repeat (68) @(negedge clk);
        rst_pin = 1'b1;
        #1;
        check("t6_rst_tx", tx[0], 1);
        check("t6_rst_count", cnt_of(0), 0);
        check("t6_rst_busy", busy[0], 0);
        check("t6_rst_empty", empty[0], 1);
        repeat (3) @(negedge clk);
        rst_pin = 1'b0;
        sb.delete();
        errs = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (tx[0] !== 1'b1 || busy[0] !== 1'b0) errs++;
        end
        check("t6_quiet_after_reset", errs, 0);
        wr(0, 8'h5A);
        check("t6_tx_before_pop", tx[0], 1);
        check("t6_count_after_write", cnt_of(0), 1);
        @(negedge clk);
        check("t6_tx_fall", tx[0], 0);
        check("t6_busy", busy[0], 1);
        expect_frame(0, 0, 1, t0a);
        repeat (20) @(negedge clk);
        check("t6_final_idle", idle_ok(0), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo_param.md
Name: uart_tx_fifo_param

Overview:
Parametrised UART transmitter with an input byte FIFO. It generalises the fixed 8N1, 9600-baud serial format used on the uart_tx_out line of the system. It adds configurable data width, parity and stop bits, and back-to-back frames with no idle gap. It sits between the design's character/text generators and the uart_tx_out pin, decoupling producers from the slow serial line.

Parameters:
CLKS_PER_BIT, 10416, clock cycles per serial bit (100 MHz / 9600 baud); must be >= 2
DATA_BITS, 8, data bits per frame, 5..9, sent LSB first
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, 1 or 2
FIFO_DEPTH, 16, FIFO entries; must be a power of 2
FIFO_AW, 4, log2(FIFO_DEPTH)

Ports:
clk  in  1  system clock, rising edge
rst_pin  in  1  reset, asynchronous, active-high
wr_en  in  1  push wr_data into FIFO this cycle
wr_data  in  DATA_BITS  character to transmit
full  out  1  FIFO holds FIFO_DEPTH entries (registered)
empty  out  1  FIFO holds 0 entries (registered)
count  out  FIFO_AW+1  current FIFO occupancy
overflow  out  1  one-cycle pulse: write attempted while full
busy  out  1  high whenever the serializer is not in IDLE
uart_tx_out  out  1  serial line, idle high, registered

Behaviour:
- Reset (async, rst_pin=1) forces:
  - uart_tx_out=1, busy=0, overflow=0, full=0, empty=1, count=0
  - FIFO pointers 0; FSM in IDLE; bit and cycle counters 0
- Reset takes effect immediately, including mid-frame. The line returns high and any partial frame is abandoned; no further output until new writes.
- FIFO:
  - A write is accepted when wr_en=1 and registered full=0.
  - wr_en=1 while full=1: data is dropped, FIFO unchanged, and overflow=1 for exactly the next cycle. This holds even if a pop occurs in the same cycle.
  - Write and pop in the same cycle: count unchanged, both pointers advance.
  - Pointers wrap modulo FIFO_DEPTH. full and empty are derived from count, updated on the same edge.
- Serializer FSM: IDLE -> START -> DATA -> PARITY (skipped when PARITY=0) -> STOP -> IDLE or START.
  - IDLE: uart_tx_out=1. If empty=0, pop the head into the shift register, drive uart_tx_out=0, and enter START on the same edge.
  - START: 1 bit-time at 0.
  - DATA: DATA_BITS bit-times, LSB first.
  - PARITY: 1 bit-time.
    - even: XOR of data bits
    - odd: inverted XOR of data bits
  - STOP: STOP_BITS bit-times at 1.
  - At the last cycle of the final stop bit:
    - if empty=0: pop and enter START directly, with no idle cycle between frames
    - else: return to IDLE
- Bit timing: every bit holds exactly CLKS_PER_BIT cycles. A cycle counter runs 0..CLKS_PER_BIT-1 and resets at each bit boundary.
- Frame length is (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * CLKS_PER_BIT cycles.
- Latency: a write into an empty FIFO while IDLE is sampled at edge k. count=1 after edge k. The FSM pops at edge k+1, so uart_tx_out falls at edge k+1.
- busy is high from the popping edge until return to IDLE. It stays continuously high across back-to-back frames.
- Data bits above DATA_BITS do not exist; wr_data is exactly DATA_BITS wide.

Test Plan:
1. Reset:
   - stimulus: hold rst_pin=1 for 100 cycles, then release
   - required: uart_tx_out=1, empty=1, full=0, count=0, busy=0, overflow=0 throughout; line stays high with no writes.
2. Single frame, CLKS_PER_BIT=16, defaults otherwise:
   - stimulus: write 0x53 ('S')
   - required: line low 1 cycle after the write edge, then 16 cycles start=0, then data 1,1,0,0,1,0,1,0 at 16 cycles each, then stop=1 for 16 cycles; busy high for exactly 160 cycles.
3. Back-to-back:
   - stimulus: write 'S' then 'A' (0x41) on consecutive cycles
   - required: second start bit begins on the cycle right after the 16th stop cycle of the first frame; busy never drops; total 320 busy cycles; decoded bytes 0x53, 0x41.
4. Parity and stop bits, 0x41, CLKS_PER_BIT=16:
   - PARITY=2, STOP_BITS=2: parity bit 0, frame 192 cycles
   - PARITY=1: parity bit 1
5. Overflow, FIFO_DEPTH=4, FIFO_AW=2:
   - stimulus: write bytes 0x10..0x15 on 6 consecutive cycles
   - required: 0x10 popped immediately; 0x11..0x14 fill the FIFO (full=1); 0x15 dropped with overflow high exactly 1 cycle; line transmits 0x10..0x14 in order.
6. Reset mid-frame:
   - stimulus: assert rst_pin during data bit 3 of a frame, with 2 bytes still queued
   - required: uart_tx_out=1 and count=0 immediately; no further frames until a new write, which is then sent with normal latency.
